// File: rtl/pong_match_ctrl.sv
// ---------------------------------------------------------------------------
// pong_match_ctrl
//
// Match sequencer for the pong game. Runs the IDLE / SERVE / RALLY / POINT /
// OVER state machine, keeps both scores, and drives the paddle and ball
// reset/launch controls. Timing is counted in video frames (frame_tick).
//
// Optional feature: define PONG_ATTRACT_EN to build the attract (demo) mode,
// which starts a computer-vs-computer match after ATTRACT_FRAMES idle frames.
// Without it, IDLE waits for a start edge and attract is tied low.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-low reset
//   frame_tick   in   one-cycle pulse per video frame
//   start        in   start button level (acts on rising edge)
//   mode[1:0]    in   [1] left paddle AI, [0] right paddle AI, sampled on start
//   miss_left    in   ball passed left paddle (right scores)
//   miss_right   in   ball passed right paddle (left scores)
//   paddle_reset out  holds both paddles centred (active high)
//   ball_reset   out  holds ball centred (active high)
//   ball_launch  out  one-cycle launch pulse
//   serve_dir    out  launch direction, 1 = toward left
//   ai_left      out  left paddle AI select
//   ai_right     out  right paddle AI select
//   score_left   out  left score (4 bits)
//   score_right  out  right score (4 bits)
//   winner[1:0]  out  00 none, 10 left won, 01 right won
//   attract      out  attract mode active
//   state[2:0]   out  debug state: IDLE 0, SERVE 1, RALLY 2, POINT 3, OVER 4
// ---------------------------------------------------------------------------
module pong_match_ctrl #(
    parameter int WIN_SCORE      = 7,
    parameter int SERVE_FRAMES   = 60,
    parameter int POINT_FRAMES   = 90,
    parameter int ATTRACT_FRAMES = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       paddle_reset,
    output logic       ball_reset,
    output logic       ball_launch,
    output logic       serve_dir,
    output logic       ai_left,
    output logic       ai_right,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] winner,
    output logic       attract,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [9:0] SERVE_LD_C = 10'(SERVE_FRAMES);
    localparam logic [9:0] POINT_LD_C = 10'(POINT_FRAMES);
    localparam logic [3:0] WIN_C      = 4'(WIN_SCORE);

    // Registered state and outputs
    state_t     state_r;
    logic [9:0] cnt_r;
    logic       start_q_r;
    logic       paddle_reset_r, ball_reset_r, ball_launch_r, serve_dir_r;
    logic       ai_left_r, ai_right_r;
    logic [3:0] score_left_r, score_right_r;
    logic [1:0] winner_r;

    // Next-state values
    state_t     state_nx_s;
    logic [9:0] cnt_nx_s;
    logic       paddle_reset_nx_s, ball_reset_nx_s, ball_launch_nx_s, serve_dir_nx_s;
    logic       ai_left_nx_s, ai_right_nx_s;
    logic [3:0] score_left_nx_s, score_right_nx_s;
    logic [1:0] winner_nx_s;
    logic       attract_nx_s;

    logic       attract_s;
    logic       start_edge_s;
    logic       lone_miss_left_s, lone_miss_right_s;
    logic [3:0] score_left_inc_s, score_right_inc_s;

`ifdef PONG_ATTRACT_EN
    localparam logic [9:0] ATTRACT_LAST_C = 10'(ATTRACT_FRAMES - 1);
    logic attract_r;
    assign attract_s = attract_r;
`else
    // Attract mode is not built; the parameter is only kept for a uniform
    // parameter list across builds.
    logic [9:0] unused_attract_frames_s;
    assign unused_attract_frames_s = 10'(ATTRACT_FRAMES);
    assign attract_s = 1'b0;
`endif

    // start_q resets high so a button held through reset produces no edge.
    assign start_edge_s      = start & ~start_q_r;
    // Simultaneous misses cancel each other.
    assign lone_miss_left_s  = miss_left & ~miss_right;
    assign lone_miss_right_s = miss_right & ~miss_left;
    assign score_left_inc_s  = score_left_r + 4'd1;
    assign score_right_inc_s = score_right_r + 4'd1;

    // Next-state and next-output logic for the match sequencer
    always_comb begin
        state_nx_s        = state_r;
        cnt_nx_s          = cnt_r;
        paddle_reset_nx_s = paddle_reset_r;
        ball_reset_nx_s   = ball_reset_r;
        ball_launch_nx_s  = 1'b0;
        serve_dir_nx_s    = serve_dir_r;
        ai_left_nx_s      = ai_left_r;
        ai_right_nx_s     = ai_right_r;
        score_left_nx_s   = score_left_r;
        score_right_nx_s  = score_right_r;
        winner_nx_s       = winner_r;
        attract_nx_s      = attract_s;

        if (start_edge_s && ((state_r == ST_IDLE) || (state_r == ST_OVER) || attract_s)) begin
            // New match: also the way out of attract mode from any state.
            state_nx_s        = ST_SERVE;
            cnt_nx_s          = SERVE_LD_C;
            paddle_reset_nx_s = 1'b1;
            ball_reset_nx_s   = 1'b1;
            serve_dir_nx_s    = 1'b1;
            ai_left_nx_s      = mode[1];
            ai_right_nx_s     = mode[0];
            score_left_nx_s   = 4'd0;
            score_right_nx_s  = 4'd0;
            winner_nx_s       = 2'b00;
            attract_nx_s      = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    paddle_reset_nx_s = 1'b1;
                    ball_reset_nx_s   = 1'b1;
`ifdef PONG_ATTRACT_EN
                    // Count idle frames; after ATTRACT_FRAMES start a demo match.
                    if (frame_tick) begin
                        if (cnt_r == ATTRACT_LAST_C) begin
                            state_nx_s     = ST_SERVE;
                            cnt_nx_s       = SERVE_LD_C;
                            serve_dir_nx_s = 1'b1;
                            ai_left_nx_s   = 1'b1;
                            ai_right_nx_s  = 1'b1;
                            attract_nx_s   = 1'b1;
                        end else begin
                            cnt_nx_s = cnt_r + 10'd1;
                        end
                    end else begin
                        cnt_nx_s = cnt_r;
                    end
`endif
                end
                ST_SERVE: begin
                    paddle_reset_nx_s = 1'b1;
                    ball_reset_nx_s   = 1'b1;
                    if (frame_tick) begin
                        if (cnt_r == 10'd1) begin
                            state_nx_s        = ST_RALLY;
                            paddle_reset_nx_s = 1'b0;
                            ball_reset_nx_s   = 1'b0;
                            ball_launch_nx_s  = 1'b1;
                        end else begin
                            cnt_nx_s = cnt_r - 10'd1;
                        end
                    end else begin
                        cnt_nx_s = cnt_r;
                    end
                end
                ST_RALLY: begin
                    paddle_reset_nx_s = 1'b0;
                    ball_reset_nx_s   = 1'b0;
                    if (lone_miss_left_s || lone_miss_right_s) begin
                        serve_dir_nx_s = lone_miss_left_s;
                        if (attract_s) begin
                            // Demo play: no scoring, never ends.
                            state_nx_s      = ST_POINT;
                            ball_reset_nx_s = 1'b1;
                            cnt_nx_s        = POINT_LD_C;
                        end else if (lone_miss_left_s && (score_right_inc_s == WIN_C)) begin
                            score_right_nx_s = score_right_inc_s;
                            state_nx_s       = ST_OVER;
                            ball_reset_nx_s  = 1'b1;
                            winner_nx_s      = 2'b01;
                        end else if (lone_miss_right_s && (score_left_inc_s == WIN_C)) begin
                            score_left_nx_s = score_left_inc_s;
                            state_nx_s      = ST_OVER;
                            ball_reset_nx_s = 1'b1;
                            winner_nx_s     = 2'b10;
                        end else begin
                            if (lone_miss_left_s) begin
                                score_right_nx_s = score_right_inc_s;
                            end else begin
                                score_left_nx_s = score_left_inc_s;
                            end
                            state_nx_s      = ST_POINT;
                            ball_reset_nx_s = 1'b1;
                            cnt_nx_s        = POINT_LD_C;
                        end
                    end else begin
                        state_nx_s = ST_RALLY;
                    end
                end
                ST_POINT: begin
                    paddle_reset_nx_s = 1'b0;
                    ball_reset_nx_s   = 1'b1;
                    if (frame_tick) begin
                        if (cnt_r == 10'd1) begin
                            state_nx_s        = ST_SERVE;
                            paddle_reset_nx_s = 1'b1;
                            cnt_nx_s          = SERVE_LD_C;
                        end else begin
                            cnt_nx_s = cnt_r - 10'd1;
                        end
                    end else begin
                        cnt_nx_s = cnt_r;
                    end
                end
                ST_OVER: begin
                    paddle_reset_nx_s = 1'b0;
                    ball_reset_nx_s   = 1'b1;
                end
                default: begin
                    // Unreachable encoding: fall back to the safe idle state.
                    state_nx_s        = ST_IDLE;
                    cnt_nx_s          = 10'd0;
                    paddle_reset_nx_s = 1'b1;
                    ball_reset_nx_s   = 1'b1;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 10'd0;
            start_q_r      <= 1'b1;
            paddle_reset_r <= 1'b1;
            ball_reset_r   <= 1'b1;
            ball_launch_r  <= 1'b0;
            serve_dir_r    <= 1'b1;
            ai_left_r      <= 1'b0;
            ai_right_r     <= 1'b0;
            score_left_r   <= 4'd0;
            score_right_r  <= 4'd0;
            winner_r       <= 2'b00;
        end else begin
            state_r        <= state_nx_s;
            cnt_r          <= cnt_nx_s;
            start_q_r      <= start;
            paddle_reset_r <= paddle_reset_nx_s;
            ball_reset_r   <= ball_reset_nx_s;
            ball_launch_r  <= ball_launch_nx_s;
            serve_dir_r    <= serve_dir_nx_s;
            ai_left_r      <= ai_left_nx_s;
            ai_right_r     <= ai_right_nx_s;
            score_left_r   <= score_left_nx_s;
            score_right_r  <= score_right_nx_s;
            winner_r       <= winner_nx_s;
        end
    end

`ifdef PONG_ATTRACT_EN
    // Attract mode flag register
    always_ff @(posedge clk) begin
        if (!reset) begin
            attract_r <= 1'b0;
        end else begin
            attract_r <= attract_nx_s;
        end
    end
    assign attract = attract_r;
`else
    logic unused_attract_nx_s;
    assign unused_attract_nx_s = attract_nx_s;
    assign attract = 1'b0;
`endif

    assign state        = state_r;
    assign paddle_reset = paddle_reset_r;
    assign ball_reset   = ball_reset_r;
    assign ball_launch  = ball_launch_r;
    assign serve_dir    = serve_dir_r;
    assign ai_left      = ai_left_r;
    assign ai_right     = ai_right_r;
    assign score_left   = score_left_r;
    assign score_right  = score_right_r;
    assign winner       = winner_r;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_match_ctrl
//
// Scoreboard bench for pong_match_ctrl. Stimulus pushes each expected output
// snapshot, together with the cycle at which it must appear, into a queue.
// A monitor samples the outputs after every rising edge; whenever the
// snapshot changes it pops the next expectation and compares value and cycle.
// Any change with nothing expected is also reported.
// ---------------------------------------------------------------------------
module tb_pong_match_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       pr;
        logic       br;
        logic       bl;
        logic       sd;
        logic       al;
        logic       ar;
        logic [3:0] sl;
        logic [3:0] sr;
        logic [1:0] w;
        logic       at;
    } snap_t;

    localparam snap_t RESET_SNAP = '{st: 3'd0, pr: 1'b1, br: 1'b1, bl: 1'b0, sd: 1'b1,
                                     al: 1'b0, ar: 1'b0, sl: 4'd0, sr: 4'd0, w: 2'b00, at: 1'b0};

    logic       clk = 1'b0;
    logic       reset, frame_tick, start, miss_left, miss_right;
    logic [1:0] mode;
    logic       paddle_reset, ball_reset, ball_launch, serve_dir, ai_left, ai_right, attract;
    logic [3:0] score_left, score_right;
    logic [1:0] winner;
    logic [2:0] state;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    snap_t e;
    snap_t exp_q[$];
    int    cyc_q[$];
    string name_q[$];

    pong_match_ctrl #(
        .WIN_SCORE(3), .SERVE_FRAMES(3), .POINT_FRAMES(2), .ATTRACT_FRAMES(5)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .mode(mode),
        .miss_left(miss_left), .miss_right(miss_right),
        .paddle_reset(paddle_reset), .ball_reset(ball_reset), .ball_launch(ball_launch),
        .serve_dir(serve_dir), .ai_left(ai_left), .ai_right(ai_right),
        .score_left(score_left), .score_right(score_right), .winner(winner),
        .attract(attract), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare each output change against the next expectation.
    initial begin
        snap_t prev, cur, ex;
        int    ec;
        string nm;
        prev = '1;
        forever begin
            @(posedge clk);
            #1;
            cur = '{st: state, pr: paddle_reset, br: ball_reset, bl: ball_launch, sd: serve_dir,
                    al: ai_left, ar: ai_right, sl: score_left, sr: score_right, w: winner, at: attract};
            if (cur !== prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change cycle=%0d got=%h", cyc, cur);
                end else begin
                    ex = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    nm = name_q.pop_front();
                    if ((cur !== ex) || (cyc != ec)) begin
                        n_fail++;
                        $display("FAIL %s got=%h at cycle %0d, expected=%h at cycle %0d",
                                 nm, cur, cyc, ex, ec);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic push(input string nm, input int ofs);
        exp_q.push_back(e);
        cyc_q.push_back(cyc + ofs);
        name_q.push_back(nm);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic miss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        @(negedge clk);
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    // From a fresh SERVE: launch after the third tick, pulse lasts one cycle.
    task automatic serve_to_rally(input string nm);
        e.st = 3'd2; e.pr = 1'b0; e.br = 1'b0; e.bl = 1'b1;
        push(nm, 3);
        e.bl = 1'b0;
        push({nm, "_end"}, 4);
        ticks(3);
        @(negedge clk);
    endtask

    // From a fresh POINT: back to SERVE on the second tick.
    task automatic point_to_serve(input string nm);
        e.st = 3'd1; e.pr = 1'b1; e.br = 1'b1;
        push(nm, 2);
        ticks(2);
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; mode = 2'b00; frame_tick = 1'b0;
        miss_left = 1'b0; miss_right = 1'b0;

        // Reset with start held: no match may begin on release.
        e = RESET_SNAP;
        push("reset_state", 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);

        // Start edge with a coincident tick (not counted), mode = 10.
        e.st = 3'd1; e.al = 1'b1; e.ar = 1'b0;
        push("start_serve", 1);
        mode = 2'b10; start = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; start = 1'b0;
        ticks(1);
        start = 1'b1;                 // edge in SERVE is ignored
        @(negedge clk);
        start = 1'b0;
        e.st = 3'd2; e.pr = 1'b0; e.br = 1'b0; e.bl = 1'b1;
        push("first_launch", 2);
        e.bl = 1'b0;
        push("first_launch_end", 3);
        ticks(2);
        @(negedge clk);

        // Rally: simultaneous misses ignored, then lone miss_left.
        miss(1'b1, 1'b1);
        e.st = 3'd3; e.br = 1'b1; e.sr = 4'd1; e.sd = 1'b1;
        push("miss_left_point", 1);
        miss(1'b1, 1'b0);
        miss(1'b1, 1'b0);             // ignored in POINT
        point_to_serve("point_serve");
        miss(1'b1, 1'b0);             // ignored in SERVE
        serve_to_rally("launch2");

        // Left wins with three miss_right pulses.
        for (int k = 1; k <= 3; k++) begin
            e.sl = 4'(k); e.sd = 1'b0; e.br = 1'b1;
            if (k < 3) begin
                e.st = 3'd3;
                push("miss_right_point", 1);
                miss(1'b0, 1'b1);
                point_to_serve("serve_again");
                serve_to_rally("relaunch");
            end else begin
                e.st = 3'd4; e.w = 2'b10;
                push("left_wins", 1);
                miss(1'b0, 1'b1);
            end
        end
        miss(1'b1, 1'b0);             // ignored in OVER

        // Restart from OVER with mode = 01.
        e = RESET_SNAP;
        e.st = 3'd1; e.ar = 1'b1;
        push("restart_serve", 1);
        mode = 2'b01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ticks(2);

        // Reset on the launching tick cancels the launch.
        e = RESET_SNAP;
        push("mid_match_reset", 1);
        reset = 1'b0; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

`ifdef PONG_ATTRACT_EN
        ticks(4);
        e.st = 3'd1; e.at = 1'b1; e.al = 1'b1; e.ar = 1'b1;
        push("attract_serve", 1);
        ticks(1);
        serve_to_rally("attract_launch");
        e.st = 3'd3; e.br = 1'b1;
        push("attract_miss_left", 1);
        miss(1'b1, 1'b0);
        point_to_serve("attract_point_serve");
        serve_to_rally("attract_launch2");
        e.st = 3'd3; e.br = 1'b1; e.sd = 1'b0;
        push("attract_miss_right", 1);
        miss(1'b0, 1'b1);
        e = RESET_SNAP;
        e.st = 3'd1;
        push("attract_exit_start", 1);
        mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`else
        ticks(8);                     // IDLE waits; nothing may change
`endif

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expectations got=%0d left, expected=0 (next %s)",
                     exp_q.size(), name_q[0]);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
